// File: rtl/upload_frame_packer_if.sv
// Upload-side producer bus plus framed TX byte stream of the upload frame packer.
// master: the producer / downstream sink side; slave: the packer itself.
interface upload_frame_packer_if;
    logic       upload_active;
    logic       upload_req;
    logic [7:0] upload_data;
    logic [7:0] upload_source;
    logic       upload_valid;
    logic       upload_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output upload_active, upload_req, upload_data, upload_source, upload_valid,
        input  upload_ready,
        input  tx_data, tx_valid,
        output tx_ready
    );

    modport slave (
        input  upload_active, upload_req, upload_data, upload_source, upload_valid,
        output upload_ready,
        output tx_data, tx_valid,
        input  tx_ready
    );
endinterface

// File: rtl/upload_frame_packer.sv
// Upload frame packer: buffers one upload burst (up to MAX_PAYLOAD bytes) and
// replays it as HDR0 HDR1 SRC LEN_H LEN_L PAYLOAD[LEN] CSUM on the TX byte stream.
// The whole burst must be held because LEN goes out ahead of the payload.
module upload_frame_packer #(
    parameter int         MAX_PAYLOAD = 64,
    parameter logic [7:0] HDR0        = 8'hAA,
    parameter logic [7:0] HDR1        = 8'h44
) (
    input  logic                 clk,
    input  logic                 rst_n,
    upload_frame_packer_if.slave up,
    output logic                 busy
);
    localparam int            CW      = $clog2(MAX_PAYLOAD + 1);
    localparam int            AW      = $clog2(MAX_PAYLOAD);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAYLOAD);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_COLLECT = 4'd1;
    localparam logic [3:0] S_HDR0    = 4'd2;
    localparam logic [3:0] S_HDR1    = 4'd3;
    localparam logic [3:0] S_SRC     = 4'd4;
    localparam logic [3:0] S_LEN_H   = 4'd5;
    localparam logic [3:0] S_LEN_L   = 4'd6;
    localparam logic [3:0] S_PAYLOAD = 4'd7;
    localparam logic [3:0] S_CSUM    = 4'd8;

    logic [3:0]    state, state_n;
    logic [CW-1:0] count, count_n;
    logic [CW-1:0] rd_ptr, rd_ptr_n;
    logic [7:0]    src, src_n;
    logic [7:0]    csum, csum_n;
    logic [7:0]    tx_data_n;
    logic          tx_valid_n;
    logic [15:0]   len;
    logic [7:0]    rd_byte;
    logic          accept;
    logic          tx_fire;
    logic [7:0]    mem [MAX_PAYLOAD];

    // The producer already folds its request into upload_valid, so req is informational only.
    logic unused_req;
    assign unused_req = up.upload_req;

    assign accept          = up.upload_valid && up.upload_ready;
    assign tx_fire         = up.tx_valid && up.tx_ready;
    assign up.upload_ready = (state == S_COLLECT) && (count < MAX_CNT);
    assign busy            = (state != S_IDLE);
    assign len             = 16'(count);
    assign rd_byte         = mem[rd_ptr[AW-1:0]];

    // Next-state, counters, latched source and running checksum.
    always_comb begin
        state_n  = state;
        count_n  = count;
        rd_ptr_n = rd_ptr;
        src_n    = src;
        csum_n   = csum;
        case (state)
            S_IDLE: begin
                if (up.upload_active) begin
                    state_n = S_COLLECT;
                    count_n = '0;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    count_n = count + CW'(1);
                    if (count == '0)
                        src_n = up.upload_source;
                end
                // count_n so a byte taken on the falling edge of upload_active still ships
                if (count == MAX_CNT || (!up.upload_active && count_n != '0)) begin
                    state_n  = S_HDR0;
                    rd_ptr_n = '0;
                    csum_n   = src_n;
                end else if (!up.upload_active) begin
                    state_n = S_IDLE;
                end
            end
            S_HDR0:  if (tx_fire) state_n = S_HDR1;
            S_HDR1:  if (tx_fire) state_n = S_SRC;
            S_SRC:   if (tx_fire) state_n = S_LEN_H;
            S_LEN_H: begin
                if (tx_fire) begin
                    state_n = S_LEN_L;
                    csum_n  = csum + len[15:8];
                end
            end
            S_LEN_L: begin
                if (tx_fire) begin
                    state_n = S_PAYLOAD;
                    csum_n  = csum + len[7:0];
                end
            end
            S_PAYLOAD: begin
                if (tx_fire) begin
                    csum_n   = csum + rd_byte;
                    rd_ptr_n = rd_ptr + CW'(1);
                    if (rd_ptr == count - CW'(1))
                        state_n = S_CSUM;
                end
            end
            S_CSUM: begin
                if (tx_fire) begin
                    // still active means the buffer filled up: keep collecting the same burst
                    if (up.upload_active) begin
                        state_n = S_COLLECT;
                        count_n = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Output byte for the state being entered, so tx_data is a flop that holds while stalled.
    always_comb begin
        tx_data_n  = '0;
        tx_valid_n = (state_n != S_IDLE) && (state_n != S_COLLECT);
        case (state_n)
            S_HDR0:    tx_data_n = HDR0;
            S_HDR1:    tx_data_n = HDR1;
            S_SRC:     tx_data_n = src_n;
            S_LEN_H:   tx_data_n = len[15:8];
            S_LEN_L:   tx_data_n = len[7:0];
            S_PAYLOAD: tx_data_n = mem[rd_ptr_n[AW-1:0]];
            S_CSUM:    tx_data_n = csum_n;
            default:   tx_data_n = '0;
        endcase
    end

    // Control and output registers; reset drops any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            count       <= '0;
            rd_ptr      <= '0;
            src         <= '0;
            csum        <= '0;
            up.tx_valid <= 1'b0;
            up.tx_data  <= '0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            rd_ptr      <= rd_ptr_n;
            src         <= src_n;
            csum        <= csum_n;
            up.tx_valid <= tx_valid_n;
            up.tx_data  <= tx_data_n;
        end
    end

    // Payload buffer; contents are don't-care outside a frame so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept)
            mem[count[AW-1:0]] <= up.upload_data;
    end
endmodule

// File: tb/tb_upload_frame_packer.sv
// Scoreboard bench for upload_frame_packer: the producer task feeds a frame-level
// model that pushes expected TX bytes; an independent monitor pops and compares.
module tb_upload_frame_packer;
    localparam int MAXP = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   popped   = 0;
    int   rdy_mode = 0;

    logic [7:0] exp_q[$];
    logic [7:0] stim[$];
    logic [7:0] frm[$];
    logic [7:0] frm_src;

    upload_frame_packer_if bus();

    upload_frame_packer #(.MAX_PAYLOAD(MAXP), .HDR0(8'hAA), .HDR1(8'h44)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (bus),
        .busy  (busy)
    );

    assign bus.upload_valid = bus.upload_req & bus.upload_ready;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a frame is SRC of its first byte, 16-bit big-endian length, payload, mod-256 sum.
    function automatic void emit_frame();
        logic [15:0] len;
        logic [7:0]  sum;
        len = 16'(frm.size());
        sum = frm_src + len[15:8] + len[7:0];
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h44);
        exp_q.push_back(frm_src);
        exp_q.push_back(len[15:8]);
        exp_q.push_back(len[7:0]);
        foreach (frm[i]) begin
            exp_q.push_back(frm[i]);
            sum = sum + frm[i];
        end
        exp_q.push_back(sum);
        frm.delete();
    endfunction

    function automatic void model_accept(input logic [7:0] d, input logic [7:0] s);
        if (frm.size() == 0) frm_src = s;
        frm.push_back(d);
        if (frm.size() == MAXP) emit_frame();
    endfunction

    function automatic void model_end();
        if (frm.size() != 0) emit_frame();
    endfunction

    // Offer every byte of stim as one burst; bytes the packer takes go to the model.
    task automatic send_burst(input bit rand_src, input logic [7:0] src, input int gap_pct,
                              input bit early_fall);
        int         sent;
        int         guard;
        int         n;
        logic [7:0] s;
        sent  = 0;
        guard = 0;
        n     = stim.size();
        @(posedge clk); #1;
        bus.upload_active = 1'b1;
        while (sent < n && guard < 1000) begin
            s = rand_src ? 8'($urandom) : src;
            bus.upload_source = s;
            bus.upload_data   = stim[sent];
            bus.upload_req    = ($urandom_range(99) >= gap_pct);
            if (early_fall && sent == n - 1 && bus.upload_req && bus.upload_ready)
                bus.upload_active = 1'b0;
            @(negedge clk);
            if (bus.upload_valid) begin
                model_accept(stim[sent], s);
                sent++;
            end
            @(posedge clk); #1;
            guard++;
        end
        bus.upload_req    = 1'b0;
        bus.upload_active = 1'b0;
        chk("burst_bytes_accepted", sent, n);
        model_end();
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || busy) && g < 400) begin
            @(negedge clk); #1;
            g++;
        end
        chk("expected_bytes_left", exp_q.size(), 0);
        chk("idle_after_frame", busy, 0);
    endtask

    // Downstream sink: always ready, toggling, or random.
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = ~bus.tx_ready;
                default: bus.tx_ready = 1'($urandom);
            endcase
        end
    end

    // Monitor: pops the scoreboard on each TX handshake and checks stall/back-pressure rules.
    initial begin
        logic       stall_pend;
        logic [7:0] stall_data;
        logic [7:0] e;
        stall_pend = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_pend = 1'b0;
            end else begin
                if (stall_pend) begin
                    chk("stall_valid_held", bus.tx_valid, 1);
                    chk("stall_data_held", bus.tx_data, stall_data);
                end
                if (bus.tx_valid)
                    chk("upload_ready_while_draining", bus.upload_ready, 0);
                if (bus.tx_valid && bus.tx_ready) begin
                    popped++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_tx: got %02h with no byte expected", bus.tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", bus.tx_data, e);
                    end
                end
                stall_pend = bus.tx_valid && !bus.tx_ready;
                stall_data = bus.tx_data;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int g;
        int t0;
        int p0;
        bus.upload_active = 1'b0;
        bus.upload_req    = 1'b0;
        bus.upload_data   = '0;
        bus.upload_source = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx_valid", bus.tx_valid, 0);
        chk("reset_tx_data", bus.tx_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_upload_ready", bus.upload_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // two-byte burst, frame on consecutive cycles
        rdy_mode = 0;
        stim = {8'h12, 8'h34};
        send_burst(1'b0, 8'h07, 0, 1'b0);
        g = 0;
        do begin
            @(negedge clk); #1;
            g++;
        end while (!bus.tx_valid && g < 50);
        t0 = cyc;
        g  = 0;
        while (exp_q.size() != 0 && g < 50) begin
            @(negedge clk); #1;
            g++;
        end
        chk("frame_cycle_span", cyc - t0, 7);
        wait_idle();

        // active pulse without data: no frame
        @(posedge clk); #1;
        bus.upload_active = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.upload_active = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("empty_pulse_busy", busy, 0);
        chk("empty_pulse_tx_valid", bus.tx_valid, 0);

        // six bytes into a four-byte buffer: forced flush then remainder
        stim.delete();
        repeat (6) stim.push_back(8'h01);
        send_burst(1'b0, 8'h07, 0, 1'b0);
        wait_idle();

        // same two-byte burst with a toggling sink
        rdy_mode = 1;
        stim = {8'h12, 8'h34};
        send_burst(1'b0, 8'h07, 0, 1'b0);
        wait_idle();

        // last byte taken in the cycle upload_active falls
        rdy_mode = 0;
        stim = {8'h5A, 8'hC3, 8'h99};
        send_burst(1'b0, 8'h21, 0, 1'b1);
        wait_idle();

        // reset in the middle of the payload
        stim = {8'hDE, 8'hAD, 8'hBE};
        p0 = popped;
        send_burst(1'b0, 8'h07, 0, 1'b0);
        g = 0;
        while (popped < p0 + 6 && g < 100) begin
            @(negedge clk); #1;
            g++;
        end
        chk("bytes_before_reset", popped - p0, 6);
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_tx_valid", bus.tx_valid, 0);
        chk("midframe_reset_tx_data", bus.tx_data, 0);
        chk("midframe_reset_busy", busy, 0);
        chk("midframe_reset_upload_ready", bus.upload_ready, 0);
        exp_q.delete();
        frm.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stim = {8'h11, 8'h22, 8'h33};
        send_burst(1'b0, 8'h09, 0, 1'b0);
        wait_idle();

        // randomized bursts, sources, gaps and sink behaviour
        for (int b = 0; b < 40; b++) begin
            int n;
            n = $urandom_range(1, 10);
            stim.delete();
            for (int k = 0; k < n; k++) stim.push_back(8'($urandom));
            rdy_mode = $urandom_range(0, 2);
            send_burst(1'b1, 8'h00, 30, 1'($urandom_range(0, 1)));
            wait_idle();
        end

        rdy_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("final_expected_bytes_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
